// File: rtl/vserial_fifo.sv
// Buffered console port: H-bus writes feed a TX FIFO drained every DRAIN_DIV cycles,
// plus a one-entry RX holding register and a status register. VSERIAL_DISPLAY_EN echoes tx to the console.
module vserial_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 16
) (
  input  logic                  Hclock,
  input  logic                  Hreset,
  input  logic                  Hsize,
  input  logic                  Hwrite,
  input  logic [31:0]           Hwritedata,
  input  logic [2:0]            Haddress,
  input  logic                  Hselect,
  input  logic                  ready,
  output logic [31:0]           Hreaddata,
  output logic                  Hready,
  output logic                  Hresponse,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0] ADDR_DATA   = 3'b000;
  localparam logic [2:0] ADDR_STATUS = 3'b100;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, rx_hold_q, rx_hold_d;
  logic                  tx_valid_q, tx_valid_d, rx_hold_valid_q, rx_hold_valid_d;

  logic acc, is_data, is_status, tx_full, tx_empty, push, pop, rd_clear, rx_take;
  logic unused_bus;

  assign unused_bus = ^{Hsize, Hwritedata};

  // Bus decode, handshake and combinational read data
  always_comb begin
    acc       = Hselect & ready & ~Hreset;
    is_data   = (Haddress == ADDR_DATA);
    is_status = (Haddress == ADDR_STATUS);
    tx_full   = (count_q == CNT_FULL);
    tx_empty  = (count_q == '0);
    Hready    = ~(acc & Hwrite & is_data & tx_full);
    Hresponse = acc & ~is_data & ~is_status;
    push      = acc & Hwrite & is_data & ~tx_full;
    pop       = ~tx_empty & (div_cnt_q == DIV_LAST);
    rd_clear  = acc & ~Hwrite & is_data & rx_hold_valid_q;
    rx_take   = rx_valid & ~rx_hold_valid_q;
    Hreaddata = '0;
    if (acc && !Hwrite) begin
      if (is_data && rx_hold_valid_q) begin
        Hreaddata[31]             = 1'b1;
        Hreaddata[DATA_WIDTH-1:0] = rx_hold_q;
      end else if (is_status) begin
        Hreaddata[0]    = tx_full;
        Hreaddata[1]    = tx_empty;
        Hreaddata[2]    = rx_hold_valid_q;
        Hreaddata[15:8] = 8'(count_q);
      end
    end
  end

  // Next-state: FIFO, drain timer, RX holding register
  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q + PTR_W'(push);
    rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    div_cnt_d       = (tx_empty || pop) ? '0 : div_cnt_q + DIV_W'(1);
    tx_valid_d      = pop;
    tx_data_d       = tx_data_q;
    rx_hold_d       = rx_hold_q;
    rx_hold_valid_d = rx_hold_valid_q;
    if (push) mem_d[wr_ptr_q] = Hwritedata[DATA_WIDTH-1:0];
    if (pop)  tx_data_d = mem_q[rd_ptr_q];
    if (rd_clear) begin
      rx_hold_valid_d = 1'b0;
    end else if (rx_take) begin
      rx_hold_valid_d = 1'b1;
      rx_hold_d       = rx_data;
    end
  end

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      div_cnt_q       <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      rx_hold_q       <= '0;
      rx_hold_valid_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      div_cnt_q       <= div_cnt_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      rx_hold_q       <= rx_hold_d;
      rx_hold_valid_q <= rx_hold_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign rx_ready = ~rx_hold_valid_q;
  assign irq      = rx_hold_valid_q;

`ifdef VSERIAL_DISPLAY_EN
  // Simulation-only console echo of each drained character
  always @(posedge Hclock) begin
    if (tx_valid_q) $write("%c", tx_data_q);
  end
`else
`endif

endmodule

// File: tb/tb_vserial_fifo.sv
// Scoreboard bench for vserial_fifo: expected TX characters queued on committed writes,
// checked as tx_valid pulses appear; bus and RX behaviour checked against fixed expectations.
module tb_vserial_fifo;

  logic        Hclock = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hsize = 1'b0;
  logic        Hwrite = 1'b0;
  logic [31:0] Hwritedata = '0;
  logic [2:0]  Haddress = '0;
  logic        Hselect = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] Hreaddata;
  logic        Hready, Hresponse;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int tx_pulses = 0;
  int last_tx_cyc = 0;
  logic [7:0] exp_q [$];

  vserial_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DRAIN_DIV(16)) dut (
    .Hclock(Hclock), .Hreset(Hreset), .Hsize(Hsize), .Hwrite(Hwrite),
    .Hwritedata(Hwritedata), .Haddress(Haddress), .Hselect(Hselect), .ready(ready),
    .Hreaddata(Hreaddata), .Hready(Hready), .Hresponse(Hresponse),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .irq(irq)
  );

  always #5 Hclock = ~Hclock;
  always @(posedge Hclock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every drained character must match the oldest committed write
  always @(posedge Hclock) begin
    #2;
    if (tx_valid === 1'b1) begin
      tx_pulses++;
      last_tx_cyc = cyc_cnt;
      if (exp_q.size() == 0) check("tx_spurious", 32'(tx_valid), 32'd0);
      else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic bus_idle();
    Hselect = 1'b0; ready = 1'b0; Hwrite = 1'b0; Haddress = '0; Hwritedata = '0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                           output int stalls, output logic resp, output int commit_cyc);
    logic [31:0] dv;
    dv = d;
    Hselect = 1'b1; ready = 1'b1; Hwrite = 1'b1; Haddress = a; Hwritedata = d;
    stalls = 0;
    #1;
    resp = Hresponse;
    while (Hready !== 1'b1 && stalls < 200) begin
      @(posedge Hclock); #1;
      stalls++;
      #1;
    end
    if (Hready !== 1'b1) check("wr_stall_timeout", 32'(Hready), 32'd1);
    else if (a == 3'b000) exp_q.push_back(dv[7:0]);
    @(posedge Hclock); #1;
    commit_cyc = cyc_cnt;
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] data, output logic resp);
    Hselect = 1'b1; ready = 1'b1; Hwrite = 1'b0; Haddress = a;
    #1;
    data = Hreaddata;
    resp = Hresponse;
    @(posedge Hclock); #1;
    bus_idle();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge Hclock); #3;
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (20) @(posedge Hclock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, cc, p0, n, tot;
    logic resp;
    logic [31:0] rd;

    // Reset values, with a STATUS read held on the bus
    repeat (2) @(posedge Hclock);
    #1;
    Hselect = 1'b1; ready = 1'b1; Haddress = 3'b100;
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_hready", 32'(Hready), 32'd1);
    check("rst_hresp", 32'(Hresponse), 32'd0);
    check("rst_rdata", Hreaddata, 32'd0);
    bus_idle();
    Hreset = 1'b0;
    @(posedge Hclock); #1;
    bus_read(3'b100, rd, resp);
    check("post_rst_status", rd, 32'h0000_0002);

    // 1: single character latency
    p0 = tx_pulses;
    bus_write(3'b000, 32'h41, stalls, resp, cc);
    check("t1_stall", 32'(stalls), 32'd0);
    check("t1_resp", 32'(resp), 32'd0);
    wait_drain(100);
    check("t1_pulses", 32'(tx_pulses - p0), 32'd1);
    check("t1_latency", 32'(last_tx_cyc - cc), 32'd16);
    bus_read(3'b100, rd, resp);
    check("t1_status", rd, 32'h0000_0002);

    // 2: fill FIFO, 17th write stalls until the first pop
    p0 = tx_pulses;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      bus_write(3'b000, 32'h30 + 32'(i), stalls, resp, cc);
      tot += stalls;
    end
    check("t2_fill_stalls", 32'(tot), 32'd0);
    bus_write(3'b000, 32'h40, stalls, resp, cc);
    check("t2_full_stalls", 32'(stalls), 32'd1);
    bus_read(3'b100, rd, resp);
    check("t2_status_full", rd, 32'h0000_1001);
    wait_drain(400);
    check("t2_pulses", 32'(tx_pulses - p0), 32'd17);

    // 3: RX injection and clearing read
    check("t3_rx_ready_idle", 32'(rx_ready), 32'd1);
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(posedge Hclock); #1;
    rx_valid = 1'b0;
    check("t3_rx_ready_full", 32'(rx_ready), 32'd0);
    check("t3_irq_set", 32'(irq), 32'd1);
    bus_read(3'b000, rd, resp);
    check("t3_read", rd, 32'h8000_005A);
    check("t3_irq_clr", 32'(irq), 32'd0);
    check("t3_rx_ready_clr", 32'(rx_ready), 32'd1);
    bus_read(3'b000, rd, resp);
    check("t3_read_empty", rd, 32'h0000_0000);

    // 4: injection in the clearing-read cycle is refused, retry captures
    rx_data = 8'h11; rx_valid = 1'b1;
    @(posedge Hclock); #1;
    rx_valid = 1'b0;
    Hselect = 1'b1; ready = 1'b1; Hwrite = 1'b0; Haddress = 3'b000;
    rx_data = 8'h22; rx_valid = 1'b1;
    #1;
    check("t4_read", Hreaddata, 32'h8000_0011);
    @(posedge Hclock); #1;
    bus_idle();
    check("t4_not_captured", 32'(irq), 32'd0);
    @(posedge Hclock); #1;
    rx_valid = 1'b0;
    check("t4_captured", 32'(irq), 32'd1);
    bus_read(3'b000, rd, resp);
    check("t4_read2", rd, 32'h8000_0022);

    // 5: unmapped address and STATUS write
    bus_write(3'b010, 32'h77, stalls, resp, cc);
    check("t5_wr_resp", 32'(resp), 32'd1);
    bus_read(3'b010, rd, resp);
    check("t5_rd_resp", 32'(resp), 32'd1);
    check("t5_rd_data", rd, 32'd0);
    bus_write(3'b100, 32'h55, stalls, resp, cc);
    check("t5_status_wr_resp", 32'(resp), 32'd0);
    repeat (20) @(posedge Hclock);
    #1;
    bus_read(3'b100, rd, resp);
    check("t5_status", rd, 32'h0000_0002);

    // 6: reset mid-drain
    p0 = tx_pulses;
    for (int i = 0; i < 5; i++) bus_write(3'b000, 32'h61 + 32'(i), stalls, resp, cc);
    n = 0;
    while (tx_pulses - p0 < 2 && n < 200) begin
      @(posedge Hclock); #3;
      n++;
    end
    check("t6_two_pulses", 32'(tx_pulses - p0), 32'd2);
    Hreset = 1'b1;
    #1;
    check("t6_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    check("t6_rx_ready", 32'(rx_ready), 32'd1);
    Hselect = 1'b1; ready = 1'b1; Hwrite = 1'b0; Haddress = 3'b100;
    #1;
    check("t6_hready", 32'(Hready), 32'd1);
    check("t6_hresp", 32'(Hresponse), 32'd0);
    check("t6_rdata", Hreaddata, 32'd0);
    bus_idle();
    exp_q.delete();
    @(posedge Hclock); #1;
    Hreset = 1'b0;
    p0 = tx_pulses;
    repeat (100) @(posedge Hclock);
    #1;
    check("t6_no_more_tx", 32'(tx_pulses - p0), 32'd0);
    bus_read(3'b100, rd, resp);
    check("t6_status", rd, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vserial_fifo.md
Name: vserial_fifo

Overview:
Buffered, parametrised successor to the simulation console port on the CPU's H-bus. It takes CPU writes into a TX FIFO of depth FIFO_DEPTH and drains one character every DRAIN_DIV cycles onto a character stream. It also adds a one-entry RX holding register fed by the bench, plus a status register. It sits on the peripheral bus slot used for console I/O.

Parameters:
DATA_WIDTH, 8, character width; bits [DATA_WIDTH-1:0] of write data are used.
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
DRAIN_DIV, 16, cycles per drained character; minimum 1.

Ports:
Hclock  input  1  clock, rising edge.
Hreset  input  1  asynchronous, active-high reset.
Hsize  input  1  transfer size; accepted but unused.
Hwrite  input  1  1 = write, 0 = read.
Hwritedata  input  32  write data.
Haddress  input  3  register select.
Hselect  input  1  slave select.
ready  input  1  bus phase valid.
Hreaddata  output  32  read data.
Hready  output  1  0 = stall the current transfer.
Hresponse  output  1  1 = error (unmapped address).
rx_data  input  DATA_WIDTH  character injected by the bench.
rx_valid  input  1  rx_data valid.
rx_ready  output  1  RX holding register can accept.
tx_data  output  DATA_WIDTH  drained character.
tx_valid  output  1  one-cycle pulse per drained character.
irq  output  1  level; high while RX holding register is full.

Behaviour:
- Access condition: acc = Hselect & ready. A transfer commits when acc & Hready.
- Address map:
  - 3'b000 DATA: write pushes a TX character; read pops RX.
  - 3'b100 STATUS: read only; writes are ignored with no error.
  - Any other address: Hresponse=1 combinationally while acc; writes are ignored; reads return 0.
- Hready is combinational. Hready=0 only when acc & Hwrite & Haddress==000 & tx_full; otherwise 1. A stalled write commits on the first cycle tx_full is 0.
- Read data is combinational, valid in the same cycle as acc:
  - DATA: {rx_hold_valid, 23'b0, rx_hold}. Returns 0 if the holding register is empty.
  - STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_hold_valid, bits[15:8] tx_count (zero-extended), all other bits 0.
- A committed DATA read clears rx_hold_valid at the next edge. A DATA read while empty has no side effect.
- TX FIFO: circular buffer with pointer width log2(FIFO_DEPTH) and a count of width log2(FIFO_DEPTH)+1.
  - Push on a committed DATA write.
  - A push and a pop in the same cycle leaves the count unchanged.
  - tx_full when count==FIFO_DEPTH; tx_empty when count==0.
  - Pointers wrap modulo FIFO_DEPTH.
- Drain timer: div_cnt counts 0..DRAIN_DIV-1 only while the FIFO is non-empty; it holds at 0 while the FIFO is empty.
  - When div_cnt==DRAIN_DIV-1 and the FIFO is non-empty: pop the head, register it into tx_data, assert tx_valid for exactly one cycle, and reset div_cnt to 0.
  - First-character latency: a push at edge N makes tx_valid high during the cycle after edge N+DRAIN_DIV.
  - With DRAIN_DIV=1, characters drain one per cycle, back to back.
- Full FIFO with a pop in the same cycle: a stalled write sees tx_full from the registered count. It commits in the following cycle, never in the pop cycle.
- RX path:
  - rx_ready = ~rx_hold_valid.
  - On rx_valid & rx_ready, capture rx_data and set rx_hold_valid.
  - A read clearing the register and an rx_valid in the same cycle: the injection is not accepted because rx_ready=0. The bench retries the next cycle.
- irq = rx_hold_valid.
- Reset (async assert, released synchronously by the system):
  - FIFO pointers, count, div_cnt, rx_hold and rx_hold_valid cleared to 0.
  - tx_valid=0, tx_data=0.
  - Outputs under reset: rx_ready=1, irq=0, Hready=1, Hresponse=0, Hreaddata=0.
  - Reset mid-drain discards all FIFO contents; no tx_valid is issued.

Optional Feature:
VSERIAL_DISPLAY_EN:
- Defined: each tx_valid pulse prints tx_data as a character to the simulator console ($write "%c") in the same cycle tx_valid is high. Not synthesisable; simulation builds only.
- Undefined: no console output; the tx_data/tx_valid ports are the only observation point.

Test Plan:
1. Reset, then write 0x41 to DATA with DRAIN_DIV=16 -> Hready=1 and the write commits. tx_valid pulses exactly once, 16 cycles after the push edge, with tx_data=0x41. STATUS reads 0x0000_0002 afterwards.
2. Write 16 characters 0x30..0x3F back to back, then a 17th (0x40) -> the 17th write sees Hready=0 until the first pop. It then commits, and STATUS[15:8] never exceeds 16. Drained order is 0x30..0x40, one character per 16 cycles.
3. Drive rx_data=0x5A with rx_valid=1 -> rx_ready falls and irq=1. A DATA read returns 0x8000_005A; the next cycle irq=0 and rx_ready=1. A second read returns 0x0000_0000.
4. Drive rx_valid=1 in the same cycle as a clearing DATA read -> the injection is not captured. Holding rx_valid one more cycle captures it.
5. Read and write at address 3'b010 -> Hresponse=1 and Hreaddata=0; FIFO count unchanged.
6. Push 5 characters, assert Hreset after the 2nd tx_valid pulse -> all outputs return to reset values immediately. No further tx_valid occurs and STATUS reads 0x0000_0002.
